// File: rtl/vrf_pkg.sv
// Shared types for the vector register file write-back path.
package vrf_pkg;

    localparam int unsigned VEC_W      = 16;
    localparam int unsigned VREG_N     = 32;
    localparam int unsigned VREG_IDX_W = 5;

    typedef logic [VEC_W-1:0][VEC_W-1:0] vec_t;
    typedef logic [VREG_IDX_W-1:0]       vreg_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the priority flop flips to the other requester after a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    // Grants are masked during reset so requesters never see ready while held in reset.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req[0] && (!req[1] || !prio)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// VRF write-port arbiter with registered write stage and busy scoreboard.
// Optional contention counter built when VRF_WB_STATS_EN is defined.
module vrf_wb_arbiter
    import vrf_pkg::*;
#(
    parameter int unsigned WIDTH = VEC_W,
    parameter int unsigned NREQ  = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NREQ-1:0]                          req_valid,
    input  logic [NREQ-1:0][VREG_IDX_W-1:0]          req_rd,
    input  logic [NREQ-1:0][WIDTH-1:0][WIDTH-1:0]    req_wd,
    output logic [NREQ-1:0]                          req_ready,
    input  logic                                     issue_valid,
    input  logic                                     issue_we,
    input  logic [VREG_IDX_W-1:0]                    issue_rs1,
    input  logic [VREG_IDX_W-1:0]                    issue_rs2,
    input  logic [VREG_IDX_W-1:0]                    issue_rs3,
    input  logic [VREG_IDX_W-1:0]                    issue_rd,
    output logic                                     issue_stall,
    output logic                                     WEV,
    output logic [VREG_IDX_W-1:0]                    RD,
    output logic [WIDTH-1:0][WIDTH-1:0]              WD,
    output logic [15:0]                              conflict_cnt
);

    logic [1:0]        gnt;
    logic [VREG_N-1:0] busy_q;
    logic [VREG_N-1:0] busy_d;
    logic              issue_set;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt)
    );

    assign req_ready = gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WEV <= 1'b0;
            RD  <= '0;
            WD  <= '0;
        end else begin
            WEV <= |gnt;
            if (gnt[1]) begin
                RD <= req_rd[1];
                WD <= req_wd[1];
            end else if (gnt[0]) begin
                RD <= req_rd[0];
                WD <= req_wd[0];
            end
        end
    end

    assign issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rs3]
                                        | (issue_we & busy_q[issue_rd]));
    assign issue_set   = issue_valid & issue_we & ~issue_stall;

    // Clear first so a same-cycle set on the committing index wins.
    always_comb begin
        busy_d = busy_q;
        if (WEV) begin
            busy_d[RD] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef VRF_WB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else if ((&req_valid) && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Self-checking bench for vrf_wb_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_vrf_wb_arbiter;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0][4:0]       req_rd;
    logic [1:0][255:0]     req_wd;
    logic [1:0]            req_ready;
    logic                  issue_valid;
    logic                  issue_we;
    logic [4:0]            issue_rs1;
    logic [4:0]            issue_rs2;
    logic [4:0]            issue_rs3;
    logic [4:0]            issue_rd;
    logic                  issue_stall;
    logic                  WEV;
    logic [4:0]            RD;
    logic [15:0][15:0]     WD;
    logic [15:0]           conflict_cnt;

`ifdef VRF_WB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_busy [32];
    int         m_prio;
    bit         m_wev;
    logic [4:0] m_rd;
    logic [255:0] m_wd;
    int         m_cnt;
    int         last_g;

    vrf_wb_arbiter u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_wd       (req_wd),
        .req_ready    (req_ready),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rs3    (issue_rs3),
        .issue_rd     (issue_rd),
        .issue_stall  (issue_stall),
        .WEV          (WEV),
        .RD           (RD),
        .WD           (WD),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_prio = 0;
        m_wev  = 1'b0;
        m_rd   = '0;
        m_wd   = '0;
        m_cnt  = 0;
    endtask

    // One clock: check combinational outputs before the edge, registered outputs after it.
    task automatic step();
        int         g;
        bit         st;
        logic [1:0] er;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (req_valid[0] && req_valid[1]) g = m_prio;
            else if (req_valid[0])            g = 0;
            else if (req_valid[1])            g = 1;
        end
        st = !rst && issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rs3]
                                     || (issue_we && m_busy[issue_rd]));
        er = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        check("req_ready", 256'(req_ready), 256'(er));
        check("issue_stall", 256'(issue_stall), 256'(st));
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (m_wev) m_busy[m_rd] = 1'b0;
            if (issue_valid && issue_we && !st) m_busy[issue_rd] = 1'b1;
            if (STATS && req_valid[0] && req_valid[1] && m_cnt < 65535) m_cnt++;
            if (g >= 0) begin
                m_wev  = 1'b1;
                m_rd   = req_rd[g];
                m_wd   = req_wd[g];
                m_prio = 1 - g;
            end else begin
                m_wev = 1'b0;
            end
        end
        last_g = g;
        check("WEV", 256'(WEV), 256'(m_wev));
        check("RD", 256'(RD), 256'(m_rd));
        check("WD", WD, m_wd);
        check("conflict_cnt", 256'(conflict_cnt), 256'(m_cnt));
    endtask

    task automatic idle_inputs();
        req_valid   = 2'b00;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        issue_rs3   = 5'd0;
        issue_rd    = 5'd0;
    endtask

    initial begin
        rst    = 1'b1;
        req_rd = '0;
        req_wd = '0;
        last_g = -1;
        idle_inputs();
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();

        // Reset in the middle of an accepted write
        req_valid[0] = 1'b1;
        req_rd[0]    = 5'd4;
        req_wd[0]    = rand_vec();
        issue_valid  = 1'b1;
        issue_we     = 1'b1;
        issue_rd     = 5'd3;
        step();
        check("rst_pre_wev", 256'(WEV), 256'(1'b1));
        issue_we  = 1'b0;
        issue_rs1 = 5'd3;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_wev", 256'(WEV), 256'(1'b0));
        check("rst_ready", 256'(req_ready), 256'(2'b00));
        check("rst_busy", 256'(issue_stall), 256'(1'b0));
        check("rst_cnt", 256'(conflict_cnt), 256'(16'd0));
        step();
        rst = 1'b0;
        idle_inputs();
        step();
        check("rst_no_write", 256'(WEV), 256'(1'b0));

        // Contention: grants alternate starting from requester 0
        req_valid = 2'b11;
        req_rd[0] = 5'd10;
        req_rd[1] = 5'd11;
        for (int i = 0; i < 4; i++) begin
            req_wd[0] = rand_vec();
            req_wd[1] = rand_vec();
            step();
            check("cont_gnt", 256'(last_g), 256'(i % 2));
        end
        check("cont_cnt", 256'(conflict_cnt), STATS ? 256'd4 : 256'd0);
        req_valid = 2'b00;
        step();

        // Single requester
        req_valid[0] = 1'b1;
        req_rd[0]    = 5'd5;
        req_wd[0]    = {16{16'h1111}};
        step();
        check("single_wev", 256'(WEV), 256'(1'b1));
        check("single_rd", 256'(RD), 256'(5'd5));
        check("single_wd", WD, {16{16'h1111}});
        req_valid = 2'b00;
        step();

        // Scoreboard: rd=7 becomes busy, a reader of 7 stalls until after the commit
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = 5'd7;
        step();
        issue_we  = 1'b0;
        issue_rd  = 5'd0;
        issue_rs2 = 5'd7;
        #1 check("sb_stall_set", 256'(issue_stall), 256'(1'b1));
        req_valid[1] = 1'b1;
        req_rd[1]    = 5'd7;
        req_wd[1]    = rand_vec();
        step();
        req_valid = 2'b00;
        check("sb_commit_rd", 256'(RD), 256'(5'd7));
        #1 check("sb_stall_commit", 256'(issue_stall), 256'(1'b1));
        step();
        #1 check("sb_stall_clear", 256'(issue_stall), 256'(1'b0));
        step();
        idle_inputs();

        // Same-cycle set and clear of register 9
        req_valid[0] = 1'b1;
        req_rd[0]    = 5'd9;
        req_wd[0]    = rand_vec();
        step();
        req_valid   = 2'b00;
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = 5'd9;
        step();
        issue_we  = 1'b0;
        issue_rd  = 5'd0;
        issue_rs1 = 5'd9;
        #1 check("setclr_stall", 256'(issue_stall), 256'(1'b1));
        step();
        idle_inputs();

        // Back-to-back writes from requester 1
        req_valid[1] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req_rd[1] = 5'(i);
            req_wd[1] = rand_vec();
            step();
            check("b2b_wev", 256'(WEV), 256'(1'b1));
            check("b2b_rd", 256'(RD), 256'(i));
        end
        req_valid = 2'b00;
        step();

        // Random traffic honouring the hold-until-ready contract
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_rd[i]    = 5'($urandom_range(0, 7));
                    req_wd[i]    = rand_vec();
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_we    = 1'($urandom_range(0, 1));
            issue_rs1   = 5'($urandom_range(0, 15));
            issue_rs2   = 5'($urandom_range(0, 15));
            issue_rs3   = 5'($urandom_range(0, 15));
            issue_rd    = 5'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
